// File: rtl/rom_2port_arbiter.sv
// Round-robin arbiter sharing a dual-port lookup ROM among NUM_REQ requesters.
// Each read is tagged with its requester id and the returned word is routed back.
module rom_2port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*AWIDTH-1:0]   i_req_addr,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic [NUM_REQ-1:0]          o_rsp_valid,
    output logic [NUM_REQ*DWIDTH-1:0]   o_rsp_data,
    output logic [AWIDTH-1:0]           o_rom_addr_a,
    output logic [AWIDTH-1:0]           o_rom_addr_b,
    input  logic [DWIDTH-1:0]           i_rom_q_a,
    input  logic [DWIDTH-1:0]           i_rom_q_b,
    output logic                        o_busy
);
    localparam int IDW = $clog2(NUM_REQ);
    typedef logic [IDW-1:0] id_t;
    typedef logic [IDW:0]   scan_t;

    id_t                          r_rr_ptr;
    logic [AWIDTH-1:0]            r_last_a, r_last_b;
    logic [ROM_LAT-1:0]           r_vld_a, r_vld_b;
    logic [ROM_LAT-1:0][IDW-1:0]  r_id_a, r_id_b;
    logic [NUM_REQ-1:0]           r_rsp_valid;
    logic [NUM_REQ*DWIDTH-1:0]    r_rsp_data;
    logic                         r_busy;

    logic                         w_gnt_a, w_gnt_b;
    id_t                          w_id_a, w_id_b;
    scan_t                        w_idx;
    logic [AWIDTH-1:0]            w_addr_a, w_addr_b;

    function automatic id_t f_next(input id_t id);
        return (id == id_t'(NUM_REQ - 1)) ? '0 : id_t'(id + 1'b1);
    endfunction

    // Grants are held off while reset is asserted so every output reads 0.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        w_id_a  = '0;
        w_id_b  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + scan_t'(k);
            if (w_idx >= scan_t'(NUM_REQ))
                w_idx = w_idx - scan_t'(NUM_REQ);
            if (i_rst_n && i_req_valid[w_idx[IDW-1:0]]) begin
                if (!w_gnt_a) begin
                    w_gnt_a = 1'b1;
                    w_id_a  = w_idx[IDW-1:0];
                end else if (!w_gnt_b) begin
                    w_gnt_b = 1'b1;
                    w_id_b  = w_idx[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (w_gnt_a) o_req_ready[w_id_a] = 1'b1;
        if (w_gnt_b) o_req_ready[w_id_b] = 1'b1;
    end

    assign w_addr_a     = i_req_addr[w_id_a*AWIDTH +: AWIDTH];
    assign w_addr_b     = i_req_addr[w_id_b*AWIDTH +: AWIDTH];
    assign o_rom_addr_a = w_gnt_a ? w_addr_a : r_last_a;
    assign o_rom_addr_b = w_gnt_b ? w_addr_b : r_last_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr    <= '0;
            r_last_a    <= '0;
            r_last_b    <= '0;
            r_vld_a     <= '0;
            r_vld_b     <= '0;
            r_id_a      <= '0;
            r_id_b      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_gnt_b)      r_rr_ptr <= f_next(w_id_b);
            else if (w_gnt_a) r_rr_ptr <= f_next(w_id_a);
            if (w_gnt_a) r_last_a <= w_addr_a;
            if (w_gnt_b) r_last_b <= w_addr_b;

            r_vld_a[0] <= w_gnt_a;
            r_id_a[0]  <= w_id_a;
            r_vld_b[0] <= w_gnt_b;
            r_id_b[0]  <= w_id_b;
            for (int s = 1; s < ROM_LAT; s++) begin
                r_vld_a[s] <= r_vld_a[s-1];
                r_id_a[s]  <= r_id_a[s-1];
                r_vld_b[s] <= r_vld_b[s-1];
                r_id_b[s]  <= r_id_b[s-1];
            end

            // Last tag stage lines up with ROM q; A and B never carry the same id.
            r_rsp_valid <= '0;
            if (r_vld_a[ROM_LAT-1]) begin
                r_rsp_valid[r_id_a[ROM_LAT-1]] <= 1'b1;
                r_rsp_data[r_id_a[ROM_LAT-1]*DWIDTH +: DWIDTH] <= i_rom_q_a;
            end
            if (r_vld_b[ROM_LAT-1]) begin
                r_rsp_valid[r_id_b[ROM_LAT-1]] <= 1'b1;
                r_rsp_data[r_id_b[ROM_LAT-1]*DWIDTH +: DWIDTH] <= i_rom_q_b;
            end

            // OR of the next-state tag valids and rsp_valid bits.
            r_busy <= w_gnt_a | w_gnt_b | (|r_vld_a) | (|r_vld_b);
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = r_busy;
endmodule

// File: tb/tb_rom_2port_arbiter.sv
// Drives a ROM_LAT=2 and a ROM_LAT=1 arbiter with the same requests and checks both
// against a cycle-level model of grants, ROM data and response timing.
module tb_rom_2port_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      rdy [2];
    logic [N-1:0]      rspv [2];
    logic [N*DW-1:0]   rspd [2];
    logic [AW-1:0]     aa [2];
    logic [AW-1:0]     ab [2];
    logic [DW-1:0]     qa [2];
    logic [DW-1:0]     qb [2];
    logic              busy [2];

    rom_2port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .ROM_LAT(2)) u_dut_l2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_addr(req_addr),
        .o_req_ready(rdy[0]), .o_rsp_valid(rspv[0]), .o_rsp_data(rspd[0]),
        .o_rom_addr_a(aa[0]), .o_rom_addr_b(ab[0]), .i_rom_q_a(qa[0]), .i_rom_q_b(qb[0]),
        .o_busy(busy[0]));

    rom_2port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .ROM_LAT(1)) u_dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_addr(req_addr),
        .o_req_ready(rdy[1]), .o_rsp_valid(rspv[1]), .o_rsp_data(rspd[1]),
        .o_rom_addr_a(aa[1]), .o_rom_addr_b(ab[1]), .i_rom_q_a(qa[1]), .i_rom_q_b(qb[1]),
        .o_busy(busy[1]));

    // ROM contents mem[x] = x ^ 0xA5; registered-address ROM (2 cycles) and no-reg ROM (1 cycle).
    logic [AW-1:0] a2_1, a2_2, b2_1, b2_2, a1_1, b1_1;
    always @(posedge clk) begin
        a2_1 <= aa[0]; a2_2 <= a2_1;
        b2_1 <= ab[0]; b2_2 <= b2_1;
        a1_1 <= aa[1];
        b1_1 <= ab[1];
    end
    assign qa[0] = a2_2 ^ 8'hA5;
    assign qb[0] = b2_2 ^ 8'hA5;
    assign qa[1] = a1_1 ^ 8'hA5;
    assign qb[1] = b1_1 ^ 8'hA5;

    // Reference model state
    int            ptr;
    logic [AW-1:0] la, lb;
    logic [N-1:0]  sv [2][8];
    logic [DW-1:0] sd [2][8][N];
    logic [DW-1:0] ld [2][N];
    int            lg [2];
    int            cyc_n = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input bit rst, input logic [N-1:0] v, input logic [N*AW-1:0] a);
        int q[$];
        int ia, ib, s, lat;
        bit ga, gb;
        logic [N-1:0]    er, erv;
        logic [AW-1:0]   eaa, eab;
        logic [N*DW-1:0] erd;
        rst_n = !rst; req_valid = v; req_addr = a;
        if (rst) begin
            ptr = 0; la = '0; lb = '0;
            for (int L = 0; L < 2; L++) begin
                lg[L] = -100;
                for (int k = 0; k < 8; k++) sv[L][k] = '0;
                for (int k = 0; k < N; k++) ld[L][k] = '0;
            end
        end
        @(negedge clk);
        // Requesters in round-robin order from ptr; the first two pending ones win.
        if (!rst)
            for (int k = 0; k < N; k++)
                if (v[(ptr + k) % N]) q.push_back((ptr + k) % N);
        ga = q.size() > 0;
        gb = q.size() > 1;
        ia = ga ? q[0] : 0;
        ib = gb ? q[1] : 0;
        er = '0;
        if (ga) er[ia] = 1'b1;
        if (gb) er[ib] = 1'b1;
        eaa = ga ? a[ia*AW +: AW] : la;
        eab = gb ? a[ib*AW +: AW] : lb;
        for (int L = 0; L < 2; L++) begin
            lat = (L == 0) ? 2 : 1;
            s   = cyc_n % 8;
            erv = sv[L][s];
            for (int k = 0; k < N; k++) begin
                if (erv[k]) ld[L][k] = sd[L][s][k];
                erd[k*DW +: DW] = ld[L][k];
            end
            chk($sformatf("lat%0d c%0d req_ready", lat, cyc_n), 64'(rdy[L]), 64'(er));
            chk($sformatf("lat%0d c%0d rom_addr_a", lat, cyc_n), 64'(aa[L]), 64'(eaa));
            chk($sformatf("lat%0d c%0d rom_addr_b", lat, cyc_n), 64'(ab[L]), 64'(eab));
            chk($sformatf("lat%0d c%0d rsp_valid", lat, cyc_n), 64'(rspv[L]), 64'(erv));
            chk($sformatf("lat%0d c%0d rsp_data", lat, cyc_n), 64'(rspd[L]), 64'(erd));
            chk($sformatf("lat%0d c%0d busy", lat, cyc_n), 64'(busy[L]),
                64'(lg[L] >= cyc_n - lat - 1));
            sv[L][s] = '0;
            // A read granted now returns its word lat+1 cycles later.
            if (ga) begin
                sv[L][(cyc_n + lat + 1) % 8][ia] = 1'b1;
                sd[L][(cyc_n + lat + 1) % 8][ia] = a[ia*AW +: AW] ^ 8'hA5;
                lg[L] = cyc_n;
            end
            if (gb) begin
                sv[L][(cyc_n + lat + 1) % 8][ib] = 1'b1;
                sd[L][(cyc_n + lat + 1) % 8][ib] = a[ib*AW +: AW] ^ 8'hA5;
                lg[L] = cyc_n;
            end
        end
        if (gb)      ptr = (ib + 1) % N;
        else if (ga) ptr = (ia + 1) % N;
        if (ga) la = eaa;
        if (gb) lb = eab;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    localparam logic [N*AW-1:0] ADDR_ID = {8'd3, 8'd2, 8'd1, 8'd0};

    initial begin
        // Reset while every requester is active, then continuous requests (0,1),(2,3),...
        cyc(1, 4'hF, ADDR_ID);
        cyc(1, 4'hF, ADDR_ID);
        for (int i = 0; i < 10; i++) cyc(0, 4'hF, ADDR_ID);
        for (int i = 0; i < 4; i++)  cyc(0, 4'h0, ADDR_ID);

        // Single request from requester 2 at address 0x10 -> data 0xB5.
        cyc(1, 4'h0, '0);
        cyc(0, 4'b0100, {8'h00, 8'h10, 8'h00, 8'h00});
        for (int i = 0; i < 4; i++) cyc(0, 4'h0, '0);

        // rr_ptr is now 3: requesters 3 and 0 share one cycle, then the scan resumes at 1.
        cyc(0, 4'b1001, {8'h33, 8'h22, 8'h11, 8'h44});
        cyc(0, 4'hF, {8'h5A, 8'h6B, 8'h7C, 8'h8D});
        for (int i = 0; i < 4; i++) cyc(0, 4'h0, '0);

        // Two reads issued, reset one cycle later: their responses must never appear.
        cyc(0, 4'b0011, {8'h00, 8'h00, 8'h21, 8'h20});
        cyc(1, 4'h0, '0);
        for (int i = 0; i < 5; i++) cyc(0, 4'h0, '0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 49) == 0, N'($urandom), (N*AW)'($urandom));
        for (int i = 0; i < 5; i++) cyc(0, 4'h0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
